// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from a first-word-fall-through TX FIFO and
// serialises them LSB first with optional parity and one or two stop bits.
module uart_tx_engine #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en,
   input  logic       tx_empty,
   input  logic [7:0] uart_data,
   output logic       uart_read,
   output logic       uart_txd,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          txd_q, txd_d;

   logic bit_end;
   logic stop_last;
   logic start_ok;
   logic pop;
   logic parity_bit;

   assign bit_end    = (baud_q == BAUD_MAX);
   assign stop_last  = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);
   assign start_ok   = tx_en && !tx_empty;
   // A new frame may only begin from IDLE or in the very last stop cycle.
   assign pop        = start_ok && ((state_q == IDLE) || stop_last);
   assign parity_bit = PARITY_ODD ? ~^data_q : ^data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         txd_q   <= txd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      data_d  = data_q;
      if (state_q != IDLE) begin
         baud_d = bit_end ? '0 : baud_q + BW'(1);
      end
      if (pop) begin
         data_d = uart_data;
      end
      case (state_q)
         IDLE: begin
            if (pop) state_d = START;
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            // bit_q doubles as the stop-bit index when two stop bits are used.
            if (stop_last) begin
               bit_d   = '0;
               state_d = pop ? START : IDLE;
            end else if (bit_end) begin
               bit_d = bit_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      txd_d = 1'b1;
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = data_d[bit_d];
         PARITY:  txd_d = parity_bit;
         default: txd_d = 1'b1;
      endcase
      uart_read = rst_n && pop;
      tx_done   = rst_n && stop_last;
      tx_busy   = (state_q != IDLE);
   end

   assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: one default-format DUT plus three parity/stop-bit
// variants, all at 4 clocks per bit, fed from queue-modelled FIFOs.
module tb_uart_tx_engine;

   localparam int CPB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       rst_req = 1'b0;
   logic       tx_en = 1'b1;
   logic       tx_empty = 1'b1;
   logic [7:0] uart_data = 8'h00;
   logic       en_p = 1'b1;
   logic       empty_p = 1'b1;
   logic [7:0] data_p = 8'h00;

   logic [3:0] rd_w, txd_w, busy_w, done_w;
   logic [3:0] rd_s = '0, txd_s = '0, busy_s = '0, done_s = '0;

   logic [7:0] fifo_q[$];
   logic [7:0] pfifo_q[$];

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_engine #(.CLKS_PER_BIT(CPB)) u_main (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_empty(tx_empty), .uart_data(uart_data),
      .uart_read(rd_w[0]), .uart_txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

   uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_en(en_p), .tx_empty(empty_p), .uart_data(data_p),
      .uart_read(rd_w[1]), .uart_txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

   uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_en(en_p), .tx_empty(empty_p), .uart_data(data_p),
      .uart_read(rd_w[2]), .uart_txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

   uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_stop2 (
      .clk(clk), .rst_n(rst_n), .tx_en(en_p), .tx_empty(empty_p), .uart_data(data_p),
      .uart_read(rd_w[3]), .uart_txd(txd_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] data;
      logic [11:0] exp_bits;
      int         nbits;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic drive_fifo();
      tx_empty  = (fifo_q.size() == 0);
      uart_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      empty_p   = (pfifo_q.size() == 0);
      data_p    = (pfifo_q.size() > 0) ? pfifo_q[0] : 8'h00;
   endtask

   // One clock: pop on the edge that ended a read cycle, refresh inputs, sample mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      rst_n = rst_req;
      if (rd_s[0] && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if ((rd_s[1] || rd_s[2] || rd_s[3]) && pfifo_q.size() > 0) void'(pfifo_q.pop_front());
      drive_fifo();
      @(negedge clk);
      rd_s   = rd_w;
      txd_s  = txd_w;
      busy_s = busy_w;
      done_s = done_w;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((|busy_s) && n < 200) begin
         tick();
         n++;
      end
      if (n == 200) chk({name, " idle timeout"}, 32'(busy_s), 32'd0);
   endtask

   task automatic wait_pop(input int sel, input string name);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!rd_s[sel] && n < 8);
      chk({name, " pop"}, 32'(rd_s[sel]), 32'd1);
   endtask

   task automatic check_frame(input int sel, input logic [11:0] exp_bits, input int nbits,
                              input logic exp_rd_last, input int drop_at, input string name);
      logic [47:0] line = '0;
      int busy_n = 0, done_n = 0, done_at = -1, rd_mid = 0;
      logic rd_last = 1'b0;
      int len = nbits * CPB;
      for (int k = 0; k < len; k++) begin
         tick();
         line[k] = txd_s[sel];
         busy_n += int'(busy_s[sel]);
         if (done_s[sel]) begin
            done_n++;
            done_at = k;
         end
         if (k < len - 1) rd_mid += int'(rd_s[sel]);
         else rd_last = rd_s[sel];
         if (k == drop_at) tx_en = 1'b0;
      end
      for (int b = 0; b < nbits; b++) begin
         chk($sformatf("%s bit%0d", name, b), 32'(line[b*CPB +: CPB]), exp_bits[b] ? 32'hF : 32'h0);
      end
      chk({name, " busy cycles"}, busy_n, len);
      chk({name, " done count"}, done_n, 1);
      chk({name, " done position"}, done_at, len - 1);
      chk({name, " read mid-frame"}, rd_mid, 0);
      chk({name, " read last cycle"}, 32'(rd_last), 32'(exp_rd_last));
   endtask

   task automatic check_idle(input int sel, input string name);
      tick();
      chk({name, " idle txd"}, 32'(txd_s[sel]), 32'd1);
      chk({name, " idle busy"}, 32'(busy_s[sel]), 32'd0);
   endtask

   vec_t vecs[8];

   initial begin
      // Serial bit k of each frame is exp_bits[k]: start, d0..d7, [parity], stop(s).
      vecs[0] = '{"main 55",    0, 8'h55, 12'b00_1_01010101_0, 10};
      vecs[1] = '{"main 00",    0, 8'h00, 12'b00_1_00000000_0, 10};
      vecs[2] = '{"even A5",    1, 8'hA5, 12'b0_1_0_10100101_0, 11};
      vecs[3] = '{"odd A5",     2, 8'hA5, 12'b0_1_1_10100101_0, 11};
      vecs[4] = '{"stop2 A5",   3, 8'hA5, 12'b1_1_0_10100101_0, 12};
      vecs[5] = '{"even 07",    1, 8'h07, 12'b0_1_1_00000111_0, 11};
      vecs[6] = '{"odd 07",     2, 8'h07, 12'b0_1_0_00000111_0, 11};
      vecs[7] = '{"stop2 07",   3, 8'h07, 12'b1_1_1_00000111_0, 12};

      // Reset state.
      tick();
      tick();
      chk("reset txd", 32'(txd_s), 32'hF);
      chk("reset busy", 32'(busy_s), 32'h0);
      chk("reset read", 32'(rd_s), 32'h0);
      chk("reset done", 32'(done_s), 32'h0);
      rst_req = 1'b1;
      tick();

      // Single frames across the four formats.
      for (int i = 0; i < 8; i++) begin
         wait_idle(vecs[i].name);
         if (vecs[i].sel == 0) fifo_q.push_back(vecs[i].data);
         else pfifo_q.push_back(vecs[i].data);
         wait_pop(vecs[i].sel, vecs[i].name);
         check_frame(vecs[i].sel, vecs[i].exp_bits, vecs[i].nbits, 1'b0, -1, vecs[i].name);
         check_idle(vecs[i].sel, vecs[i].name);
      end
      wait_idle("post table");

      // Back-to-back frames: second pop in the last stop cycle, start bit right after.
      fifo_q.push_back(8'h01);
      fifo_q.push_back(8'h80);
      wait_pop(0, "b2b");
      check_frame(0, 12'b00_1_00000001_0, 10, 1'b1, -1, "b2b first");
      check_frame(0, 12'b00_1_10000000_0, 10, 1'b0, -1, "b2b second");
      check_idle(0, "b2b");

      // Empty FIFO with tx_en held high.
      begin
         int rd_n = 0, busy_n = 0, low_n = 0;
         for (int k = 0; k < 200; k++) begin
            tick();
            rd_n += int'(rd_s[0]);
            busy_n += int'(busy_s[0]);
            low_n += int'(!txd_s[0]);
         end
         chk("empty reads", rd_n, 0);
         chk("empty busy", busy_n, 0);
         chk("empty line low", low_n, 0);
      end

      // tx_en dropped during data bit 3 with a second byte queued.
      fifo_q.push_back(8'h3C);
      fifo_q.push_back(8'h5A);
      wait_pop(0, "en drop");
      check_frame(0, 12'b00_1_00111100_0, 10, 1'b0, 17, "en drop");
      begin
         int rd_n = 0, busy_n = 0, low_n = 0;
         for (int k = 0; k < 20; k++) begin
            tick();
            rd_n += int'(rd_s[0]);
            busy_n += int'(busy_s[0]);
            low_n += int'(!txd_s[0]);
         end
         chk("en drop later reads", rd_n, 0);
         chk("en drop later busy", busy_n, 0);
         chk("en drop later line low", low_n, 0);
         chk("en drop fifo depth", fifo_q.size(), 1);
      end
      fifo_q.delete();
      drive_fifo();
      tx_en = 1'b1;

      // Reset during data bit 4 (line low), then a fresh frame from the FIFO.
      fifo_q.push_back(8'h0F);
      fifo_q.push_back(8'h96);
      wait_pop(0, "mid reset");
      for (int k = 0; k < 21; k++) tick();
      chk("mid reset bit4 low", 32'(txd_s[0]), 32'd0);
      rst_req = 1'b0;
      tick();
      chk("mid reset read gated", 32'(rd_s[0]), 32'd0);
      tick();
      chk("mid reset txd", 32'(txd_s[0]), 32'd1);
      chk("mid reset busy", 32'(busy_s[0]), 32'd0);
      chk("mid reset read", 32'(rd_s[0]), 32'd0);
      rst_req = 1'b1;
      tick();
      chk("post reset pop", 32'(rd_s[0]), 32'd1);
      check_frame(0, 12'b00_1_10010110_0, 10, 1'b0, -1, "post reset");
      check_idle(0, "post reset");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
